// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder.
// Optional parity storage is enabled by defining MEM_RESPONDER_PARITY_EN.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned DefaultAddrW = 8;
    localparam int unsigned DefaultDataW = 16;
    localparam int unsigned CntW         = 4;

    // Counter preload for a given wait length; only meaningful when wait_cycles > 0.
    function automatic logic [CntW-1:0] wait_preload(input int unsigned wait_cycles);
        return CntW'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word store with synchronous write and registered read.
// With MEM_RESPONDER_PARITY_EN defined, keeps an even-parity bit per word and flags load mismatches.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

`ifdef MEM_RESPONDER_PARITY_EN
    logic par_mem [DEPTH];
    logic err_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            par_mem[addr] <= ^wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (en) begin
            err_q <= !we && ((^mem[addr]) != par_mem[addr]);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder: request handshake, programmable wait, response handshake.
// Parity checking on loads is optional via MEM_RESPONDER_PARITY_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefaultAddrW,
    parameter int unsigned DATA_W      = DefaultDataW,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_write_q;
    logic              accept;
    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = wait_preload(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The array is touched exactly on the edge entering RESP; with no wait that is the accept edge,
    // so the live request fields are used before they land in the capture registers.
    assign access    = (state_d == StResp) && (state_q != StResp);
    assign acc_we    = (state_q == StIdle) ? req_we    : we_q;
    assign acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                rsp_write_q <= acc_we;
            end
        end
    end

    mem_responder_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .reset(reset),
        .en   (access),
        .we   (acc_we),
        .addr (acc_addr),
        .wdata(acc_wdata),
        .rdata(arr_rdata),
        .err  (arr_err)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_write_q ? wdata_q : arr_rdata;
    assign rsp_err   = arr_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the datapath control FSM's load/store requests. Accepts one request at a time over a valid/ready handshake, holds a DEPTH×DATA_W word store, and returns read data or a write acknowledge over a second valid/ready handshake after a configurable number of wait cycles. Sits between the control FSM's address/data-to-memory outputs and the datapath's data-from-memory input.

## Interface
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- DATA_W, 16, word width
- WAIT_CYCLES, 1, extra cycles between accept and access, legal 0..15
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes response
- rsp_write  out  1  response acknowledges a store
- rsp_rdata  out  DATA_W  load data, or echo of store data
- rsp_err  out  1  parity error on load (see Configuration)
- busy  out  1  transaction in flight (state ≠ IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture we/addr/wdata; go to WAIT, or RESP when WAIT_CYCLES=0.
- WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; decrement each cycle; at 0, go to RESP.
- Access edge: the edge entering RESP. Store commits the array word at that edge; load registers the array word into rsp_rdata at that edge. Store sets rsp_rdata = captured wdata.
- RESP: rsp_valid=1; rsp_write, rsp_rdata, rsp_err held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE.
- req_ready=0 in WAIT and RESP; req_valid ignored there, and no accept in the cycle of the response handshake.
- Full address range valid; no wrap logic, addresses 0 and DEPTH-1 are ordinary.
- Array contents not reset; a load of a never-written word returns undefined data.
- Reset (any state): state→IDLE, counter cleared, captured request discarded; a store still in WAIT is not committed. Stores committed before reset persist.
- Reset values: req_ready=1 (after release), rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, busy=0.

## Timing
- Accept on edge N; rsp_valid first high in cycle N+WAIT_CYCLES+1.
- Minimum issue interval: WAIT_CYCLES+2 cycles, with rsp_ready tied high.
- All outputs registered or decoded from registered state only; no combinational input→output path.
- Read is synchronous (registered), one port, never simultaneous read and write.

## Configuration
- MEM_RESPONDER_PARITY_EN defined: array stores one extra even-parity bit per word, computed from wdata at commit. On a load, parity is recomputed at the access edge; a mismatch sets rsp_err=1 for that response. Stores always give rsp_err=0.
- Undefined: no parity storage; rsp_err tied 0. Port list unchanged.

## Structure
- Package mem_responder_pkg: state enum (IDLE, WAIT, RESP), default ADDR_W/DATA_W, WAIT counter width (4).
- Sub-module mem_responder_array: storage array, sync write, registered read, parity bit when macro set. The FSM, counter, and handshake stay in mem_responder.

## Test plan
- Reset asserted mid-run, then released → req_ready=1, rsp_valid=0, rsp_rdata=0x0000, busy=0.
- WAIT_CYCLES=1, store addr 4 data 0x0005 accepted at edge N → rsp_valid in cycle N+2, rsp_write=1, rsp_rdata=0x0005. Then load addr 4 → rsp_rdata=0x0005, rsp_write=0.
- Backpressure: rsp_ready held low 5 cycles during a load of 0x1234 → rsp_valid stays 1, rsp_rdata stays 0x1234, req_ready stays 0, a concurrent req_valid is not accepted.
- Store addr 7 data 0x1234 completes. Then store addr 7 data 0xBEEF with WAIT_CYCLES=3, and reset asserted during WAIT → load addr 7 returns 0x1234.
- Boundaries: store 0xA5A5 at addr 0xFF and 0x5A5A at addr 0x00, WAIT_CYCLES=0 → loads return each value, latency 1 cycle.
- With the macro defined: store addr 3, then force the stored parity bit inverted → load addr 3 gives rsp_err=1. With the macro undefined: rsp_err=0 throughout.
